// File: rtl/bcd_tick_counter.sv
// Prescaled BCD tick counter: divides the clock to a tick rate and counts in
// BCD across DIGITS digits with up/down, pause, checked load and 7-seg decode.

module bcd_seg_dec #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    logic [6:0] seg_hi;

    always_comb begin
        seg_hi = 7'h00;
        case (digit)
            4'd0: seg_hi = 7'h3F;
            4'd1: seg_hi = 7'h06;
            4'd2: seg_hi = 7'h5B;
            4'd3: seg_hi = 7'h4F;
            4'd4: seg_hi = 7'h66;
            4'd5: seg_hi = 7'h6D;
            4'd6: seg_hi = 7'h7D;
            4'd7: seg_hi = 7'h07;
            4'd8: seg_hi = 7'h7F;
            4'd9: seg_hi = 7'h6F;
            default: seg_hi = 7'h00;
        endcase
    end

    assign seg = ACTIVE_LOW ? ~seg_hi : seg_hi;
endmodule

module bcd_tick_counter #(
    parameter int CLK_HZ         = 50000000,
    parameter int TICK_HZ        = 1,
    parameter int DIGITS         = 2,
    parameter int MODULO         = 100,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk_50MHz,
    input  logic                  clr_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tick,
    output logic                  cn,
    output logic                  load_err
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        int r;
        r      = v;
        to_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(r % 10);
            r                = r / 10;
        end
    endfunction

    localparam logic [PW-1:0]       PRE_MAX = PW'(DIV - 1);
    localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MODULO - 1);

    logic [PW-1:0]       pre_q, pre_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                tick_q, tick_d;
    logic                cn_q, cn_d;
    logic                err_q, err_d;

    logic                step;
    logic [4*DIGITS-1:0] bcd_inc, bcd_dec;
    logic                ld_ok;
    logic [31:0]         ld_bin;

    // Load value must be well-formed BCD and inside the modulus.
    always_comb begin
        ld_ok  = 1'b1;
        ld_bin = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (load_val[4*i +: 4] > 4'd9) ld_ok = 1'b0;
            ld_bin = ld_bin * 32'd10 + {28'd0, load_val[4*i +: 4]};
        end
        if (ld_bin >= 32'(MODULO)) ld_ok = 1'b0;
    end

    always_comb begin
        logic carry, borrow;
        bcd_inc = bcd_q;
        bcd_dec = bcd_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (bcd_q[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    assign step = en && (pre_q == PRE_MAX);

    always_comb begin
        pre_d  = pre_q;
        bcd_d  = bcd_q;
        tick_d = 1'b0;
        cn_d   = 1'b0;
        err_d  = 1'b0;
        if (en) pre_d = step ? '0 : pre_q + 1'b1;
        if (step) begin
            tick_d = 1'b1;
            if (up) begin
                cn_d  = (bcd_q == MAX_BCD);
                bcd_d = cn_d ? '0 : bcd_inc;
            end else begin
                cn_d  = (bcd_q == '0);
                bcd_d = cn_d ? MAX_BCD : bcd_dec;
            end
        end
        // A valid load wins over a step due on the same edge.
        if (load) begin
            if (ld_ok) begin
                bcd_d  = load_val;
                pre_d  = '0;
                tick_d = 1'b0;
                cn_d   = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge clr_n) begin
        if (!clr_n) begin
            pre_q  <= '0;
            bcd_q  <= '0;
            tick_q <= 1'b0;
            cn_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            bcd_q  <= bcd_d;
            tick_q <= tick_d;
            cn_q   <= cn_d;
            err_q  <= err_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_seg_dec #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .digit (bcd_q[4*g +: 4]),
            .seg   (seg[7*g +: 7])
        );
    end

    assign bcd      = bcd_q;
    assign tick     = tick_q;
    assign cn       = cn_q;
    assign load_err = err_q;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: a DIV=10 mod-100 instance and a mod-60 instance,
// compared every edge against an integer-arithmetic reference model.

module tb_bcd_tick_counter;
    localparam int DIV = 10;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n;
    logic        en_a, up_a, load_a, en_b, up_b, load_b;
    logic [7:0]  lv_a, lv_b, bcd_a, bcd_b;
    logic [13:0] seg_a, seg_b;
    logic        tick_a, cn_a, err_a, tick_b, cn_b, err_b;

    bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MODULO(100), .SEG_ACTIVE_LOW(1'b0)) u_a (
        .clk_50MHz(clk), .clr_n(clr_n), .en(en_a), .up(up_a), .load(load_a), .load_val(lv_a),
        .bcd(bcd_a), .seg(seg_a), .tick(tick_a), .cn(cn_a), .load_err(err_a));

    bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .MODULO(60), .SEG_ACTIVE_LOW(1'b0)) u_b (
        .clk_50MHz(clk), .clr_n(clr_n), .en(en_b), .up(up_b), .load(load_b), .load_val(lv_b),
        .bcd(bcd_b), .seg(seg_b), .tick(tick_b), .cn(cn_b), .load_err(err_b));

    typedef struct { int val; int pre; bit tick; bit cn; bit err; } mstate_t;
    typedef struct { logic [7:0] lv; logic [7:0] exp_bcd; bit exp_err; logic [13:0] exp_seg; } ldvec_t;

    mstate_t ma, mb;
    ldvec_t  lvec [6];
    int      n_chk = 0;
    int      n_err = 0;

    function automatic mstate_t mstep(mstate_t s, int md, bit rstn, bit e, bit u, bit ld, logic [7:0] lv);
        mstate_t n  = s;
        int      hi = int'(lv[7:4]);
        int      lo = int'(lv[3:0]);
        bit      ok;
        n.tick = 0; n.cn = 0; n.err = 0;
        if (!rstn) begin
            n.val = 0; n.pre = 0;
            return n;
        end
        ok = (hi <= 9) && (lo <= 9) && (hi * 10 + lo < md);
        if (ld && ok) begin
            n.val = hi * 10 + lo;
            n.pre = 0;
        end else begin
            n.err = ld;
            if (e) begin
                if (s.pre == DIV - 1) begin
                    n.pre  = 0;
                    n.tick = 1;
                    if (u) begin
                        n.cn  = (s.val == md - 1);
                        n.val = (s.val + 1) % md;
                    end else begin
                        n.cn  = (s.val == 0);
                        n.val = (s.val + md - 1) % md;
                    end
                end else begin
                    n.pre = s.pre + 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] to_bcd8(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [13:0] to_seg(int v);
        return {SEG_TAB[v / 10], SEG_TAB[v % 10]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_models();
        chk("a_bcd",  32'(bcd_a),  32'(to_bcd8(ma.val)));
        chk("a_seg",  32'(seg_a),  32'(to_seg(ma.val)));
        chk("a_tick", 32'(tick_a), 32'(ma.tick));
        chk("a_cn",   32'(cn_a),   32'(ma.cn));
        chk("a_err",  32'(err_a),  32'(ma.err));
        chk("b_bcd",  32'(bcd_b),  32'(to_bcd8(mb.val)));
        chk("b_seg",  32'(seg_b),  32'(to_seg(mb.val)));
        chk("b_tick", 32'(tick_b), 32'(mb.tick));
        chk("b_cn",   32'(cn_b),   32'(mb.cn));
        chk("b_err",  32'(err_b),  32'(mb.err));
    endtask

    task automatic step_clk();
        @(posedge clk);
        ma = mstep(ma, 100, clr_n, en_a, up_a, load_a, lv_a);
        mb = mstep(mb, 60,  clr_n, en_b, up_b, load_b, lv_b);
        #1;
        check_models();
    endtask

    initial begin
        lvec[0] = '{8'h42, 8'h42, 1'b0, {7'h66, 7'h5B}};
        lvec[1] = '{8'hA3, 8'h42, 1'b1, {7'h66, 7'h5B}};
        lvec[2] = '{8'h99, 8'h99, 1'b0, {7'h6F, 7'h6F}};
        lvec[3] = '{8'h3F, 8'h99, 1'b1, {7'h6F, 7'h6F}};
        lvec[4] = '{8'h00, 8'h00, 1'b0, {7'h3F, 7'h3F}};
        lvec[5] = '{8'h07, 8'h07, 1'b0, {7'h3F, 7'h07}};

        ma = '{default: 0};
        mb = '{default: 0};
        clr_n = 1'b1;
        en_a = 0; up_a = 1; load_a = 0; lv_a = '0;
        en_b = 0; up_b = 1; load_b = 0; lv_b = '0;

        // Reset and first tick
        #2 clr_n = 1'b0;
        #1;
        chk("rst_bcd",  32'(bcd_a),  32'h00);
        chk("rst_seg",  32'(seg_a),  32'({7'h3F, 7'h3F}));
        chk("rst_tick", 32'(tick_a), 32'd0);
        chk("rst_cn",   32'(cn_a),   32'd0);
        chk("rst_err",  32'(err_a),  32'd0);
        repeat (2) step_clk();
        clr_n = 1'b1; en_a = 1'b1; up_a = 1'b1;
        repeat (9) step_clk();
        chk("t1_early_tick", 32'(tick_a), 32'd0);
        step_clk();
        chk("t1_bcd",  32'(bcd_a),  32'h01);
        chk("t1_tick", 32'(tick_a), 32'd1);
        step_clk();
        chk("t1_tick_low", 32'(tick_a), 32'd0);

        // Up wrap: value 99 reached on edge 990 after release, wrap on 1000
        repeat (979) step_clk();
        chk("up_99",    32'(bcd_a), 32'h99);
        repeat (10) step_clk();
        chk("wrap_bcd",  32'(bcd_a),  32'h00);
        chk("wrap_cn",   32'(cn_a),   32'd1);
        chk("wrap_tick", 32'(tick_a), 32'd1);
        step_clk();
        chk("wrap_cn_low", 32'(cn_a), 32'd0);

        // Down wrap
        up_a = 1'b0; load_a = 1'b1; lv_a = 8'h01;
        step_clk();
        load_a = 1'b0;
        chk("dn_load", 32'(bcd_a), 32'h01);
        repeat (10) step_clk();
        chk("dn_00",    32'(bcd_a), 32'h00);
        chk("dn_00_cn", 32'(cn_a),  32'd0);
        repeat (10) step_clk();
        chk("dn_wrap_bcd", 32'(bcd_a), 32'h99);
        chk("dn_wrap_cn",  32'(cn_a),  32'd1);
        chk("dn_wrap_tick", 32'(tick_a), 32'd1);

        // Mod-60 instance down wrap and out-of-range load
        en_b = 1'b1; up_b = 1'b0; load_b = 1'b1; lv_b = 8'h00;
        step_clk();
        load_b = 1'b0;
        repeat (10) step_clk();
        chk("m60_wrap_bcd", 32'(bcd_b), 32'h59);
        chk("m60_wrap_cn",  32'(cn_b),  32'd1);
        en_b = 1'b0; load_b = 1'b1; lv_b = 8'h60;
        step_clk();
        load_b = 1'b0;
        chk("m60_ld_err", 32'(err_b), 32'd1);
        chk("m60_ld_bcd", 32'(bcd_b), 32'h59);
        step_clk();
        chk("m60_err_low", 32'(err_b), 32'd0);

        // Pause at prescaler=4 for 25 cycles
        load_a = 1'b1; lv_a = 8'h10; up_a = 1'b1; en_a = 1'b1;
        step_clk();
        load_a = 1'b0;
        repeat (4) step_clk();
        en_a = 1'b0;
        repeat (25) step_clk();
        chk("pause_bcd",  32'(bcd_a),  32'h10);
        chk("pause_tick", 32'(tick_a), 32'd0);
        en_a = 1'b1;
        repeat (5) step_clk();
        chk("resume_early", 32'(tick_a), 32'd0);
        step_clk();
        chk("resume_bcd",  32'(bcd_a),  32'h11);
        chk("resume_tick", 32'(tick_a), 32'd1);

        // Load vectors with counting paused
        en_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load_a = 1'b1; lv_a = lvec[i].lv;
            step_clk();
            load_a = 1'b0;
            chk($sformatf("ld%0d_bcd", i), 32'(bcd_a), 32'(lvec[i].exp_bcd));
            chk($sformatf("ld%0d_err", i), 32'(err_a), 32'(lvec[i].exp_err));
            chk($sformatf("ld%0d_seg", i), 32'(seg_a), 32'(lvec[i].exp_seg));
            step_clk();
            chk($sformatf("ld%0d_err_low", i), 32'(err_a), 32'd0);
        end

        // Async reset between edges at 0x37
        en_a = 1'b1; up_a = 1'b1; load_a = 1'b1; lv_a = 8'h37;
        step_clk();
        load_a = 1'b0;
        repeat (3) step_clk();
        chk("pre_rst_bcd", 32'(bcd_a), 32'h37);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_bcd", 32'(bcd_a), 32'h00);
        chk("arst_seg", 32'(seg_a), 32'({7'h3F, 7'h3F}));
        ma = '{default: 0};
        mb = '{default: 0};
        repeat (2) step_clk();
        clr_n = 1'b1;
        repeat (9) step_clk();
        chk("arst_early", 32'(tick_a), 32'd0);
        step_clk();
        chk("arst_bcd1", 32'(bcd_a),  32'h01);
        chk("arst_tick", 32'(tick_a), 32'd1);

        // Randomized traffic on both instances
        repeat (600) begin
            en_a   = ($urandom_range(0, 3) != 0);
            up_a   = 1'($urandom_range(0, 1));
            load_a = ($urandom_range(0, 15) == 0);
            lv_a   = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            en_b   = ($urandom_range(0, 3) != 0);
            up_b   = 1'($urandom_range(0, 1));
            load_b = ($urandom_range(0, 15) == 0);
            lv_b   = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 11))};
            step_clk();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
